// File: rtl/ul8_pkg.sv
// Shared definitions for the UL8 register bank: op width and op encoding.
package ul8_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_CLR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

endpackage

// File: rtl/reg_op_unit.sv
// Combinational read-modify-write unit: computes the new register value,
// the carry/borrow/shifted-out bit and the zero flag for one op.
module reg_op_unit
  import ul8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_writeEn
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // NOP and the reserved encoding fall through to the defaults: no write.
  always_comb begin
    o_result  = i_r;
    o_carry   = 1'b0;
    o_writeEn = 1'b0;
    case (op_e'(i_op))
      OP_LOAD: begin
        o_result  = i_data;
        o_writeEn = 1'b1;
      end
      OP_INC: begin
        o_result  = i_r + ONE;
        o_carry   = &i_r;
        o_writeEn = 1'b1;
      end
      OP_DEC: begin
        o_result  = i_r - ONE;
        o_carry   = ~|i_r;
        o_writeEn = 1'b1;
      end
      OP_CLR: begin
        o_result  = '0;
        o_writeEn = 1'b1;
      end
      OP_SHL: begin
        o_result  = {i_r[WIDTH-2:0], 1'b0};
        o_carry   = i_r[WIDTH-1];
        o_writeEn = 1'b1;
      end
      OP_SHR: begin
        o_result  = {1'b0, i_r[WIDTH-1:1]};
        o_carry   = i_r[0];
        o_writeEn = 1'b1;
      end
      default: begin
        o_result  = i_r;
        o_carry   = 1'b0;
        o_writeEn = 1'b0;
      end
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/register_bank.sv
// Bank of general-purpose registers with one read-modify-write port,
// two combinational read ports and registered carry/zero flags.
module register_bank
  import ul8_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              carry,
  output logic              zero
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_carry;
  logic             r_zero;

  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_zero;
  logic             w_writeEn;
  logic [DEPTH-1:0] w_wrSel;

  assign w_target = r_regs[wr_addr];
  assign w_wrSel  = {{(DEPTH-1){1'b0}}, 1'b1} << wr_addr;

  reg_op_unit #(.WIDTH(WIDTH)) u_opUnit (
    .i_op      (op),
    .i_r       (w_target),
    .i_data    (data_in),
    .o_result  (w_result),
    .o_carry   (w_carry),
    .o_zero    (w_zero),
    .o_writeEn (w_writeEn)
  );

  // Reset wins over any op presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_writeEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wrSel[i]) r_regs[i] <= w_result;
      end
      r_carry <= w_carry;
      r_zero  <= w_zero;
    end
  end

  // Reads see stored state only; a same-cycle write shows up after the edge.
  assign rd_data_a = r_regs[rd_addr_a];
  assign rd_data_b = r_regs[rd_addr_b];
  assign carry     = r_carry;
  assign zero      = r_zero;

endmodule

// File: tb/tb_register_bank.sv
// Directed scoreboard bench for register_bank (WIDTH=8, DEPTH=4).
module tb_register_bank;
  import ul8_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] op;
  logic [1:0] wr_addr;
  logic [7:0] data_in;
  logic [1:0] rd_addr_a;
  logic [7:0] rd_data_a;
  logic [1:0] rd_addr_b;
  logic [7:0] rd_data_b;
  logic       carry;
  logic       zero;

  typedef struct {
    string      tag;
    logic [1:0] addr;
    logic [7:0] data;
    logic       carry;
    logic       zero;
  } expT;

  expT sbQ[$];
  int  nVectors;
  int  nMiscompares;

  register_bank #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .wr_addr   (wr_addr),
    .data_in   (data_in),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareVal(input string tag, input logic [7:0] observed,
                            input logic [7:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Pops the oldest expectation and checks both read ports and the flags.
  task automatic checkOutput();
    expT e;
    if (sbQ.size() == 0) begin
      nVectors++;
      nMiscompares++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sbQ.pop_front();
    rd_addr_a = e.addr;
    rd_addr_b = e.addr;
    #1;
    compareVal({e.tag, "_rdA"}, rd_data_a, e.data);
    compareVal({e.tag, "_rdB"}, rd_data_b, e.data);
    compareVal({e.tag, "_carry"}, {7'b0, carry}, {7'b0, e.carry});
    compareVal({e.tag, "_zero"}, {7'b0, zero}, {7'b0, e.zero});
  endtask

  // Drives one op for one edge, queueing the expected result of that edge.
  task automatic applyStimulus(input string tag, input logic rst,
                               input logic [2:0] opV, input logic [1:0] addr,
                               input logic [7:0] din, input logic [7:0] expData,
                               input logic expC, input logic expZ);
    expT e;
    e.tag   = tag;
    e.addr  = addr;
    e.data  = expData;
    e.carry = expC;
    e.zero  = expZ;
    sbQ.push_back(e);
    reset     = rst;
    op        = opV;
    wr_addr   = addr;
    data_in   = din;
    rd_addr_a = addr;
    rd_addr_b = addr;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    op      = OP_NOP;
    data_in = 8'h00;
    checkOutput();
  endtask

  task automatic readCheck(input string tag, input logic [1:0] addr,
                           input logic [7:0] expected);
    rd_addr_a = addr;
    rd_addr_b = addr;
    #1;
    compareVal({tag, "_A"}, rd_data_a, expected);
    compareVal({tag, "_B"}, rd_data_b, expected);
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    reset     = 1'b1;
    op        = OP_NOP;
    wr_addr   = 2'd0;
    data_in   = 8'h00;
    rd_addr_a = 2'd0;
    rd_addr_b = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Dirty the bank, then reset it.
    applyStimulus("pre_load0", 1'b0, OP_LOAD, 2'd0, 8'h33, 8'h33, 1'b0, 1'b0);
    applyStimulus("pre_load3", 1'b0, OP_LOAD, 2'd3, 8'h44, 8'h44, 1'b0, 1'b0);
    applyStimulus("pre_dec2",  1'b0, OP_DEC,  2'd2, 8'h00, 8'hFF, 1'b1, 1'b0);
    applyStimulus("reset",     1'b1, OP_NOP,  2'd2, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) readCheck($sformatf("reset_r%0d", i), 2'(i), 8'h00);

    // LOAD: old value visible until the edge.
    op        = OP_LOAD;
    wr_addr   = 2'd2;
    data_in   = 8'hA5;
    rd_addr_a = 2'd2;
    #1;
    compareVal("load_same_cycle_old", rd_data_a, 8'h00);
    applyStimulus("load_r2", 1'b0, OP_LOAD, 2'd2, 8'hA5, 8'hA5, 1'b0, 1'b0);
    readCheck("load_r0_held", 2'd0, 8'h00);
    readCheck("load_r1_held", 2'd1, 8'h00);
    readCheck("load_r3_held", 2'd3, 8'h00);

    // Wrap boundaries.
    applyStimulus("load_ff", 1'b0, OP_LOAD, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    applyStimulus("inc_wrap", 1'b0, OP_INC, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1);
    applyStimulus("dec_wrap", 1'b0, OP_DEC, 2'd1, 8'h00, 8'hFF, 1'b1, 1'b0);

    // Shifts.
    applyStimulus("load_81", 1'b0, OP_LOAD, 2'd3, 8'h81, 8'h81, 1'b0, 1'b0);
    applyStimulus("shl",     1'b0, OP_SHL,  2'd3, 8'h00, 8'h02, 1'b1, 1'b0);
    applyStimulus("shr1",    1'b0, OP_SHR,  2'd3, 8'h00, 8'h01, 1'b0, 1'b0);
    applyStimulus("shr2",    1'b0, OP_SHR,  2'd3, 8'h00, 8'h00, 1'b1, 1'b1);

    // NOP and reserved hold everything.
    applyStimulus("nop",  1'b0, OP_NOP, 2'd3, 8'h5A, 8'h00, 1'b1, 1'b1);
    applyStimulus("rsvd", 1'b0, 3'b111, 2'd3, 8'h5A, 8'h00, 1'b1, 1'b1);
    readCheck("hold_r1", 2'd1, 8'hFF);
    readCheck("hold_r2", 2'd2, 8'hA5);

    // CLR and back-to-back chaining.
    applyStimulus("clr_r2", 1'b0, OP_CLR, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus("chain1", 1'b0, OP_INC, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0);
    applyStimulus("chain2", 1'b0, OP_INC, 2'd0, 8'h00, 8'h02, 1'b0, 1'b0);
    applyStimulus("chain3", 1'b0, OP_SHL, 2'd0, 8'h00, 8'h04, 1'b0, 1'b0);

    // Set flags, then reset with a competing INC.
    applyStimulus("dec_r3", 1'b0, OP_DEC, 2'd3, 8'h00, 8'hFF, 1'b1, 1'b0);
    applyStimulus("reset_prio", 1'b1, OP_INC, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    readCheck("reset_prio_r3", 2'd3, 8'h00);
    readCheck("reset_prio_r1", 2'd1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
